// File: rtl/tetris_pkg.sv
// tetris_pkg
//   Shared types and constants for the playfield renderer: grid dimensions,
//   the cell code type, the 12-bit cell palette and the 640x480@60 Hz VGA
//   raster timing (visible / front porch / sync / back porch per axis).
package tetris_pkg;

  localparam int GRID_ROWS = 20;
  localparam int GRID_COLS = 10;

  typedef logic [3:0] cell_t;

  // What a pixel is, decided one stage ahead of the palette lookup.
  typedef enum logic [1:0] {
    PIX_BLANK      = 2'd0,
    PIX_BACKGROUND = 2'd1,
    PIX_BORDER     = 2'd2,
    PIX_FIELD      = 2'd3
  } pix_class_t;

  // Entry n is the colour of cell code n; codes 8..15 all render white.
  localparam logic [15:0][11:0] PALETTE = {
    12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
    12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
    12'hF00, 12'h0F0, 12'h00F, 12'hF80,
    12'hA0F, 12'hFF0, 12'h0FF, 12'h111
  };

  localparam logic [11:0] BORDER_RGB     = 12'h888;
  localparam logic [11:0] BACKGROUND_RGB = 12'h000;
  localparam logic [11:0] GAP_RGB        = 12'h000;

  // Horizontal timing in pixels.
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC_W  = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC_W + H_BACK;  // 800

  // Vertical timing in lines.
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC_W  = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC_W + V_BACK;  // 525

  function automatic logic [11:0] cell_colour(input cell_t code);
    return PALETTE[code];
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing
//   Pixel-rate divider and raster counters. Knows nothing about the grid.
// Ports:
//   gm_clk    in   system clock
//   gm_rst_n  in   asynchronous active-low reset
//   pix_ce    out  one-cycle pixel enable, every PIX_DIV gm_clk cycles
//   h_cnt     out  current column, 0..H_TOTAL-1
//   v_cnt     out  current line, 0..V_TOTAL-1
//   hs_raw    out  horizontal sync for (h_cnt, v_cnt), active low
//   vs_raw    out  vertical sync for (h_cnt, v_cnt), active low
//   visible   out  (h_cnt, v_cnt) lies in the visible area
module vga_timing
  import tetris_pkg::*;
#(
  parameter int PIX_DIV = 4,
  parameter int H_VIS   = H_VISIBLE,
  parameter int H_FP    = H_FRONT,
  parameter int H_SYNC  = H_SYNC_W,
  parameter int H_BP    = H_BACK,
  parameter int V_VIS   = V_VISIBLE,
  parameter int V_FP    = V_FRONT,
  parameter int V_SYNC  = V_SYNC_W,
  parameter int V_BP    = V_BACK
) (
  input  logic       gm_clk,
  input  logic       gm_rst_n,
  output logic       pix_ce,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       visible
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
  localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
  localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  logic [DIV_W-1:0] div_cnt;

  assign pix_ce = (div_cnt == DIV_LAST);

  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      div_cnt <= '0;
    end else if (pix_ce) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign hs_raw  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign visible = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);

endmodule

// File: rtl/tetris_vga_render.sv
// tetris_vga_render
//   Renders the 20x10 playfield onto a VGA raster. The grid is copied into a
//   shadow register once per frame at the start of vertical blanking, so a
//   frame is always drawn from one consistent snapshot.
// Ports:
//   gm_clk      in   system clock (100 MHz)
//   gm_rst_n    in   asynchronous active-low reset
//   grid        in   cell codes [row][col], row 0 at top; 0 = empty
//   vga_r/g/b   out  4-bit colour channels, 0 during blanking
//   vga_hs      out  horizontal sync, active low
//   vga_vs      out  vertical sync, active low
//   frame_tick  out  one gm_clk pulse when the snapshot is taken
// RGB and sync for raster position (h,v) appear two pixel periods after the
// counters pass (h,v); both paths go through the same two stages.
module tetris_vga_render
  import tetris_pkg::*;
#(
  parameter int PIX_DIV    = 4,
  parameter int FIELD_X0   = 240,
  parameter int FIELD_Y0   = 80,
  parameter int CELL_SHIFT = 4,
  parameter int BORDER_W   = 4,
  parameter int H_VIS      = H_VISIBLE,
  parameter int H_FP       = H_FRONT,
  parameter int H_SYNC     = H_SYNC_W,
  parameter int H_BP       = H_BACK,
  parameter int V_VIS      = V_VISIBLE,
  parameter int V_FP       = V_FRONT,
  parameter int V_SYNC     = V_SYNC_W,
  parameter int V_BP       = V_BACK
) (
  input  logic                                      gm_clk,
  input  logic                                      gm_rst_n,
  input  logic [GRID_ROWS-1:0][GRID_COLS-1:0][3:0]  grid,
  output logic [3:0]                                vga_r,
  output logic [3:0]                                vga_g,
  output logic [3:0]                                vga_b,
  output logic                                      vga_hs,
  output logic                                      vga_vs,
  output logic                                      frame_tick
);

  localparam int ROW_W = $clog2(GRID_ROWS);
  localparam int COL_W = $clog2(GRID_COLS);

  localparam logic [9:0] FX0       = 10'(FIELD_X0);
  localparam logic [9:0] FX1       = 10'(FIELD_X0 + (GRID_COLS << CELL_SHIFT));
  localparam logic [9:0] FY0       = 10'(FIELD_Y0);
  localparam logic [9:0] FY1       = 10'(FIELD_Y0 + (GRID_ROWS << CELL_SHIFT));
  localparam logic [9:0] BX0       = 10'(FIELD_X0 - BORDER_W);
  localparam logic [9:0] BX1       = 10'(FIELD_X0 + (GRID_COLS << CELL_SHIFT) + BORDER_W);
  localparam logic [9:0] BY0       = 10'(FIELD_Y0 - BORDER_W);
  localparam logic [9:0] BY1       = 10'(FIELD_Y0 + (GRID_ROWS << CELL_SHIFT) + BORDER_W);
  localparam logic [9:0] CELL_MASK = 10'((1 << CELL_SHIFT) - 1);
  localparam logic [9:0] SNAP_LINE = 10'(V_VIS);

  logic       pix_ce;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hs_raw;
  logic       vs_raw;
  logic       visible;

  vga_timing #(
    .PIX_DIV (PIX_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .gm_clk   (gm_clk),
    .gm_rst_n (gm_rst_n),
    .pix_ce   (pix_ce),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .hs_raw   (hs_raw),
    .vs_raw   (vs_raw),
    .visible  (visible)
  );

  logic [GRID_ROWS-1:0][GRID_COLS-1:0][3:0] shadow_reg;

  // Snapshot on the first pixel of the first blanked line.
  logic snap;
  assign snap = pix_ce && (h_cnt == 10'd0) && (v_cnt == SNAP_LINE);

  // Stage 1: classify the current counter position.
  logic [9:0]       dx;
  logic [9:0]       dy;
  logic             in_field;
  logic             in_box;
  pix_class_t       pix_class_next;
  logic [ROW_W-1:0] row_next;
  logic [COL_W-1:0] col_next;
  logic             cell_edge_next;

  always_comb begin
    // Offsets wrap for pixels left/above the field; they are only used
    // once in_field confirms the position.
    dx             = h_cnt - FX0;
    dy             = v_cnt - FY0;
    in_field       = (h_cnt >= FX0) && (h_cnt < FX1) && (v_cnt >= FY0) && (v_cnt < FY1);
    in_box         = (h_cnt >= BX0) && (h_cnt < BX1) && (v_cnt >= BY0) && (v_cnt < BY1);
    pix_class_next = PIX_BLANK;
    row_next       = '0;
    col_next       = '0;
    cell_edge_next = 1'b0;
    if (visible) begin
      if (in_field) begin
        pix_class_next = PIX_FIELD;
        row_next       = ROW_W'(dy >> CELL_SHIFT);
        col_next       = COL_W'(dx >> CELL_SHIFT);
        // Last pixel column or row inside the cell.
        cell_edge_next = ((dx & CELL_MASK) == CELL_MASK) || ((dy & CELL_MASK) == CELL_MASK);
      end else if (in_box) begin
        pix_class_next = PIX_BORDER;
      end else begin
        pix_class_next = PIX_BACKGROUND;
      end
    end
  end

  pix_class_t       pix_class_reg;
  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_reg;
  logic             cell_edge_reg;
  logic             hs_reg;
  logic             vs_reg;

  // Stage 2: palette lookup from the shadow grid.
  cell_t       code;
  logic [11:0] rgb_next;

  always_comb begin
    code     = shadow_reg[row_reg][col_reg];
    rgb_next = BACKGROUND_RGB;
    case (pix_class_reg)
      PIX_FIELD:      rgb_next = ((code != 4'd0) && cell_edge_reg) ? GAP_RGB : cell_colour(code);
      PIX_BORDER:     rgb_next = BORDER_RGB;
      PIX_BACKGROUND: rgb_next = BACKGROUND_RGB;
      default:        rgb_next = 12'h000;
    endcase
  end

  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      shadow_reg    <= '0;
      frame_tick    <= 1'b0;
      pix_class_reg <= PIX_BLANK;
      row_reg       <= '0;
      col_reg       <= '0;
      cell_edge_reg <= 1'b0;
      hs_reg        <= 1'b1;
      vs_reg        <= 1'b1;
      vga_r         <= 4'd0;
      vga_g         <= 4'd0;
      vga_b         <= 4'd0;
      vga_hs        <= 1'b1;
      vga_vs        <= 1'b1;
    end else begin
      frame_tick <= snap;
      if (snap) begin
        shadow_reg <= grid;
      end
      if (pix_ce) begin
        pix_class_reg <= pix_class_next;
        row_reg       <= row_next;
        col_reg       <= col_next;
        cell_edge_reg <= cell_edge_next;
        hs_reg        <= hs_raw;
        vs_reg        <= vs_raw;
        vga_r         <= rgb_next[11:8];
        vga_g         <= rgb_next[7:4];
        vga_b         <= rgb_next[3:0];
        vga_hs        <= hs_reg;
        vga_vs        <= vs_reg;
      end
    end
  end

endmodule

// File: tb/tb_tetris_vga_render.sv
// tb_tetris_vga_render
//   Two instances: "dut_full" with the default 640x480 timing for sync
//   widths/periods, and "dut" with a miniature raster (56x54 total, 2 px
//   cells) so several complete frames fit in a short run.
//   Miniature geometry: field h 8..27, v 4..43; border h 6..29, v 2..45;
//   hs low h 44..49; vs low v 50..51; snapshot at (0,48).
//   Pixel P = f*3024 + v*56 + h is on the outputs from cycle 4*(P+2) after
//   reset release (cycle k = k-th posedge after release).
module tb_tetris_vga_render;

  logic gm_clk;
  logic gm_rst_n;
  logic [19:0][9:0][3:0] grid;

  logic [3:0] s_r, s_g, s_b;
  logic       s_hs, s_vs, s_ft;
  logic [3:0] f_r, f_g, f_b;
  logic       f_hs, f_vs, f_ft;

  int checks = 0;
  int errors = 0;
  int cyc;

  tetris_vga_render #(
    .PIX_DIV(4), .FIELD_X0(8), .FIELD_Y0(4), .CELL_SHIFT(1), .BORDER_W(2),
    .H_VIS(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_VIS(48), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .gm_clk(gm_clk), .gm_rst_n(gm_rst_n), .grid(grid),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .vga_hs(s_hs), .vga_vs(s_vs), .frame_tick(s_ft)
  );

  tetris_vga_render dut_full (
    .gm_clk(gm_clk), .gm_rst_n(gm_rst_n), .grid(grid),
    .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
    .vga_hs(f_hs), .vga_vs(f_vs), .frame_tick(f_ft)
  );

  initial gm_clk = 1'b0;
  always #5 gm_clk = ~gm_clk;

  always @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) cyc <= 0;
    else           cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic at_cycle(input int c);
    if (cyc > c) begin
      checks++;
      errors++;
      $error("FAIL schedule observed_cycle=%0d required_cycle=%0d", cyc, c);
    end
    while (cyc < c) @(negedge gm_clk);
  endtask

  task automatic chk_rgb(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
    $display("check %-22s cyc=%0d rgb=%03h", tag, cyc, obs);
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %-22s cyc=%0d val=%b", tag, cyc, obs);
  endtask

  initial begin
    gm_rst_n = 1'b0;
    grid = '0;
    grid[0][0]  = 4'd1;
    grid[19][9] = 4'd7;
    grid[5][3]  = 4'd12;
    grid[10][4] = 4'd2;

    repeat (3) @(negedge gm_clk);
    chk_rgb("rst_rgb", {s_r, s_g, s_b}, 12'h000);
    chk_bit("rst_hs", s_hs, 1'b1);
    chk_bit("rst_vs", s_vs, 1'b1);
    chk_bit("rst_ft", s_ft, 1'b0);
    chk_rgb("rst_full_rgb", {f_r, f_g, f_b}, 12'h000);
    chk_bit("rst_full_hs", f_hs, 1'b1);
    chk_bit("rst_full_vs", f_vs, 1'b1);
    chk_bit("rst_full_ft", f_ft, 1'b0);
    gm_rst_n = 1'b1;

    // Frame 0: sync edges, and field drawn from the cleared shadow.
    at_cycle(183);   chk_bit("hs_before_fall", s_hs, 1'b1);
    at_cycle(184);   chk_bit("hs_fall", s_hs, 1'b0);
    at_cycle(207);   chk_bit("hs_last_low", s_hs, 1'b0);
    at_cycle(208);   chk_bit("hs_rise", s_hs, 1'b1);
    at_cycle(936);   chk_rgb("f0_cell00_empty", {s_r, s_g, s_b}, 12'h111);
    at_cycle(2631);  chk_bit("full_hs_before", f_hs, 1'b1);
    at_cycle(2632);  chk_bit("full_hs_fall", f_hs, 1'b0);
                     chk_rgb("full_blank_h656", {f_r, f_g, f_b}, 12'h000);
    at_cycle(3015);  chk_bit("full_hs_last_low", f_hs, 1'b0);
    at_cycle(3016);  chk_bit("full_hs_rise", f_hs, 1'b1);
    at_cycle(5831);  chk_bit("full_hs2_before", f_hs, 1'b1);
    at_cycle(5832);  chk_bit("full_hs2_fall", f_hs, 1'b0);
    at_cycle(10755); chk_bit("ft0_before", s_ft, 1'b0);
    at_cycle(10756); chk_bit("ft0_pulse", s_ft, 1'b1);
    at_cycle(10757); chk_bit("ft0_after", s_ft, 1'b0);
    at_cycle(11207); chk_bit("vs_before_fall", s_vs, 1'b1);
    at_cycle(11208); chk_bit("vs_fall", s_vs, 1'b0);
    at_cycle(11655); chk_bit("vs_last_low", s_vs, 1'b0);
    at_cycle(11656); chk_bit("vs_rise", s_vs, 1'b1);

    // Frame 1: snapshot of the initial grid.
    at_cycle(13020); chk_rgb("f1_bg_5_4", {s_r, s_g, s_b}, 12'h000);
    at_cycle(13028); chk_rgb("f1_border_7_4", {s_r, s_g, s_b}, 12'h888);
    at_cycle(13032); chk_rgb("f1_cell00", {s_r, s_g, s_b}, 12'h0FF);
    at_cycle(13036); chk_rgb("f1_gap_col_9_4", {s_r, s_g, s_b}, 12'h000);
    at_cycle(13040); chk_rgb("f1_empty_10_4", {s_r, s_g, s_b}, 12'h111);
    at_cycle(13256); chk_rgb("f1_gap_row_8_5", {s_r, s_g, s_b}, 12'h000);
    at_cycle(14524); chk_rgb("f1_hblank_45_10", {s_r, s_g, s_b}, 12'h000);
    at_cycle(15296); chk_rgb("f1_code12", {s_r, s_g, s_b}, 12'hFFF);
    at_cycle(17544); chk_rgb("f1_code2", {s_r, s_g, s_b}, 12'hFF0);

    // Change the grid mid-frame; the rest of this frame keeps the old data.
    grid[0][0]  = 4'd6;
    grid[10][4] = 4'd5;
    grid[19][9] = 4'd3;

    at_cycle(21616); chk_rgb("f1_cell1909_old", {s_r, s_g, s_b}, 12'hF00);
    at_cycle(21844); chk_rgb("f1_gap_27_43", {s_r, s_g, s_b}, 12'h000);
    at_cycle(21848); chk_rgb("f1_border_28_43", {s_r, s_g, s_b}, 12'h888);
    at_cycle(21856); chk_rgb("f1_bg_30_43", {s_r, s_g, s_b}, 12'h000);
    at_cycle(22300); chk_rgb("f1_border_29_45", {s_r, s_g, s_b}, 12'h888);
    at_cycle(22524); chk_rgb("f1_bg_29_46", {s_r, s_g, s_b}, 12'h000);
    at_cycle(22852); chk_bit("ft1_pulse", s_ft, 1'b1);
    at_cycle(23344); chk_rgb("f1_vblank_10_50", {s_r, s_g, s_b}, 12'h000);

    // Frame 2: new snapshot visible.
    at_cycle(25128); chk_rgb("f2_cell00_new", {s_r, s_g, s_b}, 12'h0F0);
    at_cycle(29640); chk_rgb("f2_code5", {s_r, s_g, s_b}, 12'h00F);
    at_cycle(33712); chk_rgb("f2_cell1909_new", {s_r, s_g, s_b}, 12'hA0F);
    at_cycle(34096); chk_rgb("f2_border_10_44", {s_r, s_g, s_b}, 12'h888);

    // Reset mid-frame: outputs clear at once, raster restarts from (0,0).
    gm_rst_n = 1'b0;
    #1;
    chk_rgb("midrst_rgb", {s_r, s_g, s_b}, 12'h000);
    chk_bit("midrst_hs", s_hs, 1'b1);
    chk_bit("midrst_vs", s_vs, 1'b1);
    chk_bit("midrst_ft", s_ft, 1'b0);
    repeat (10) @(posedge gm_clk);
    @(negedge gm_clk);
    gm_rst_n = 1'b1;

    at_cycle(183);   chk_bit("rr_hs_before", s_hs, 1'b1);
    at_cycle(184);   chk_bit("rr_hs_fall", s_hs, 1'b0);
    at_cycle(936);   chk_rgb("rr_cell00_cleared", {s_r, s_g, s_b}, 12'h111);
    at_cycle(10756); chk_bit("rr_ft_pulse", s_ft, 1'b1);
    at_cycle(13032); chk_rgb("rr_f1_cell00", {s_r, s_g, s_b}, 12'h0F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
